// File: rtl/fc0_pkg.sv
// rtl/fc0_pkg.sv - shared types and default widths for the fc0 match stage
package fc0_pkg;

   localparam int DEF_NODE_W = 16;
   localparam int DEF_GEN_W  = 12;
   localparam int DEF_OPR_W  = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MATCH = 2'd1,
      ST_EMIT  = 2'd2
   } fc0_state_e;

   typedef struct packed {
      logic                  lr;
      logic [DEF_NODE_W-1:0] node;
      logic [DEF_GEN_W-1:0]  gen;
      logic [DEF_OPR_W-1:0]  opr;
      logic                  uni_opr;
      logic [1:0]            mem_wen;
   } token_t;

   typedef struct packed {
      logic [DEF_NODE_W-1:0] node;
      logic [DEF_GEN_W-1:0]  gen;
      logic [DEF_OPR_W-1:0]  oprl;
      logic [DEF_OPR_W-1:0]  oprr;
      logic                  uni;
      logic [1:0]            mem_wen;
   } fire_t;

endpackage

// File: rtl/fc0_match_stage_if.sv
// rtl/fc0_match_stage_if.sv - merged-token input and fired-packet output handshakes
interface fc0_match_stage_if
   import fc0_pkg::*;
#(
   parameter int NODE_W = DEF_NODE_W,
   parameter int GEN_W  = DEF_GEN_W,
   parameter int OPR_W  = DEF_OPR_W
);
   logic              in_valid;
   logic              in_ready;
   logic              lr_i;
   logic [NODE_W-1:0] node_i;
   logic [GEN_W-1:0]  gen_i;
   logic [OPR_W-1:0]  opr_i;
   logic              uni_opr_i;
   logic [1:0]        mem_wen_i;

   logic              out_valid;
   logic              out_ready;
   logic [NODE_W-1:0] node_o;
   logic [GEN_W-1:0]  gen_o;
   logic [OPR_W-1:0]  oprl_o;
   logic [OPR_W-1:0]  oprr_o;
   logic              uni_o;
   logic [1:0]        mem_wen_o;

   modport master (
      output in_valid, lr_i, node_i, gen_i, opr_i, uni_opr_i, mem_wen_i, out_ready,
      input  in_ready, out_valid, node_o, gen_o, oprl_o, oprr_o, uni_o, mem_wen_o
   );

   modport slave (
      input  in_valid, lr_i, node_i, gen_i, opr_i, uni_opr_i, mem_wen_i, out_ready,
      output in_ready, out_valid, node_o, gen_o, oprl_o, oprr_o, uni_o, mem_wen_o
   );
endinterface

// File: rtl/fc0_match_store.sv
// rtl/fc0_match_store.sv - waiting-matching store: parallel key compare, lowest-index encoders, occupancy
module fc0_match_store #(
   parameter int DEPTH = 8,
   parameter int KEY_W = 28,
   parameter int OPR_W = 32,
   localparam int IDX_W = $clog2(DEPTH),
   localparam int OCC_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [KEY_W-1:0] i_key,
   input  logic             i_lr,
   input  logic [OPR_W-1:0] i_opr,
   input  logic             i_ins,
   input  logic             i_take,
   output logic             o_opp_hit,
   output logic             o_same_hit,
   output logic             o_full,
   output logic [OPR_W-1:0] o_opp_opr,
   output logic [OCC_W-1:0] o_occ
);
   logic [DEPTH-1:0] r_vld;
   logic [DEPTH-1:0] r_lr;
   logic [KEY_W-1:0] r_key [DEPTH];
   logic [OPR_W-1:0] r_opr [DEPTH];
   logic [OCC_W-1:0] r_occ;

   logic             w_opp_hit;
   logic             w_same_hit;
   logic             w_free;
   logic [IDX_W-1:0] w_opp_idx;
   logic [IDX_W-1:0] w_free_idx;

   // Scan from the top down so the lowest matching index is the last one written.
   always_comb begin
      w_opp_hit  = 1'b0;
      w_same_hit = 1'b0;
      w_free     = 1'b0;
      w_opp_idx  = '0;
      w_free_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (r_vld[i] && (r_key[i] == i_key)) begin
            if (r_lr[i] != i_lr) begin
               w_opp_hit = 1'b1;
               w_opp_idx = IDX_W'(i);
            end else begin
               w_same_hit = 1'b1;
            end
         end
         if (!r_vld[i]) begin
            w_free     = 1'b1;
            w_free_idx = IDX_W'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld <= '0;
         r_occ <= '0;
      end else if (i_ins && w_free) begin
         r_vld[w_free_idx] <= 1'b1;
         r_lr[w_free_idx]  <= i_lr;
         r_key[w_free_idx] <= i_key;
         r_opr[w_free_idx] <= i_opr;
         r_occ             <= r_occ + OCC_W'(1);
      end else if (i_take && w_opp_hit) begin
         r_vld[w_opp_idx] <= 1'b0;
         r_occ            <= r_occ - OCC_W'(1);
      end
   end

   assign o_opp_hit  = w_opp_hit;
   assign o_same_hit = w_same_hit;
   assign o_full     = !w_free;
   assign o_opp_opr  = r_opr[w_opp_idx];
   assign o_occ      = r_occ;
endmodule

// File: rtl/fc0_match_stage.sv
// rtl/fc0_match_stage.sv - firing-control stage pairing dyadic operands; FC0_STATS_EN adds event counters
module fc0_match_stage
   import fc0_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int NODE_W = DEF_NODE_W,
   parameter int GEN_W  = DEF_GEN_W,
   parameter int OPR_W  = DEF_OPR_W,
   localparam int OCC_W = $clog2(DEPTH + 1)
) (
   input  logic                clk,
   input  logic                rst,
   fc0_match_stage_if.slave    bus,
   output logic [OCC_W-1:0]    occ_o,
   output logic                ovf_o,
   output logic                dup_o
`ifdef FC0_STATS_EN
   ,
   output logic [15:0]         fire_cnt_o,
   output logic [15:0]         store_cnt_o,
   output logic [15:0]         drop_cnt_o
`endif
);
   typedef struct packed {
      logic              lr;
      logic [NODE_W-1:0] node;
      logic [GEN_W-1:0]  gen;
      logic [OPR_W-1:0]  opr;
      logic              uni_opr;
      logic [1:0]        mem_wen;
   } tok_t;

   fc0_state_e        r_state;
   tok_t              r_tok;
   logic              r_in_ready;
   logic              r_out_valid;
   logic [NODE_W-1:0] r_node;
   logic [GEN_W-1:0]  r_gen;
   logic [OPR_W-1:0]  r_oprl;
   logic [OPR_W-1:0]  r_oprr;
   logic              r_uni;
   logic [1:0]        r_wen;
   logic              r_ovf;
   logic              r_dup;

   logic              w_in_fire;
   logic              w_out_fire;
   logic              w_bypass;
   logic              w_dyadic;
   logic              w_opp_hit;
   logic              w_same_hit;
   logic              w_full;
   logic              w_ins;
   logic              w_take;
   logic              w_drop;
   logic [OPR_W-1:0]  w_opp_opr;

   assign w_in_fire  = bus.in_valid && r_in_ready;
   assign w_out_fire = r_out_valid && bus.out_ready;
   assign w_bypass   = r_tok.uni_opr || (r_tok.mem_wen != 2'b00);
   assign w_dyadic   = (r_state == ST_MATCH) && !w_bypass;
   assign w_take     = w_dyadic && w_opp_hit;
   assign w_ins      = w_dyadic && !w_opp_hit && !w_same_hit && !w_full;
   assign w_drop     = w_dyadic && !w_opp_hit && (w_same_hit || w_full);

   fc0_match_store #(
      .DEPTH (DEPTH),
      .KEY_W (NODE_W + GEN_W),
      .OPR_W (OPR_W)
   ) u_store (
      .clk        (clk),
      .rst        (rst),
      .i_key      ({r_tok.node, r_tok.gen}),
      .i_lr       (r_tok.lr),
      .i_opr      (r_tok.opr),
      .i_ins      (w_ins),
      .i_take     (w_take),
      .o_opp_hit  (w_opp_hit),
      .o_same_hit (w_same_hit),
      .o_full     (w_full),
      .o_opp_opr  (w_opp_opr),
      .o_occ      (occ_o)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_tok       <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_node      <= '0;
         r_gen       <= '0;
         r_oprl      <= '0;
         r_oprr      <= '0;
         r_uni       <= 1'b0;
         r_wen       <= 2'b00;
         r_ovf       <= 1'b0;
         r_dup       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_in_ready <= 1'b1;
               if (w_in_fire) begin
                  r_tok      <= '{bus.lr_i, bus.node_i, bus.gen_i, bus.opr_i,
                                  bus.uni_opr_i, bus.mem_wen_i};
                  r_in_ready <= 1'b0;
                  r_state    <= ST_MATCH;
               end
            end
            ST_MATCH: begin
               if (w_bypass) begin
                  r_node      <= r_tok.node;
                  r_gen       <= r_tok.gen;
                  r_oprl      <= r_tok.opr;
                  r_oprr      <= '0;
                  r_uni       <= 1'b1;
                  r_wen       <= r_tok.mem_wen;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_EMIT;
               end else if (w_opp_hit) begin
                  // An incoming right token pairs with a waiting left, and vice versa.
                  r_node      <= r_tok.node;
                  r_gen       <= r_tok.gen;
                  r_oprl      <= r_tok.lr ? w_opp_opr : r_tok.opr;
                  r_oprr      <= r_tok.lr ? r_tok.opr : w_opp_opr;
                  r_uni       <= 1'b0;
                  r_wen       <= 2'b00;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_EMIT;
               end else begin
                  if (w_same_hit) begin
                     r_dup <= 1'b1;
                  end else if (w_full) begin
                     r_ovf <= 1'b1;
                  end
                  r_in_ready <= 1'b1;
                  r_state    <= ST_IDLE;
               end
            end
            ST_EMIT: begin
               if (w_out_fire) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_in_ready <= 1'b0;
               r_state    <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef FC0_STATS_EN
   logic [15:0] r_fire_cnt;
   logic [15:0] r_store_cnt;
   logic [15:0] r_drop_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fire_cnt  <= '0;
         r_store_cnt <= '0;
         r_drop_cnt  <= '0;
      end else begin
         if (w_take && (r_fire_cnt != 16'hFFFF)) r_fire_cnt <= r_fire_cnt + 16'd1;
         if (w_ins && (r_store_cnt != 16'hFFFF)) r_store_cnt <= r_store_cnt + 16'd1;
         if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
   end

   assign fire_cnt_o  = r_fire_cnt;
   assign store_cnt_o = r_store_cnt;
   assign drop_cnt_o  = r_drop_cnt;
`endif

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.node_o    = r_node;
   assign bus.gen_o     = r_gen;
   assign bus.oprl_o    = r_oprl;
   assign bus.oprr_o    = r_oprr;
   assign bus.uni_o     = r_uni;
   assign bus.mem_wen_o = r_wen;
   assign ovf_o         = r_ovf;
   assign dup_o         = r_dup;
endmodule

// File: tb/tb_fc0_match_stage.sv
// tb/tb_fc0_match_stage.sv - directed self-checking bench for fc0_match_stage (honours FC0_STATS_EN)
module tb_fc0_match_stage;
   import fc0_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [3:0] occ;
   logic       ovf;
   logic       dup;
`ifdef FC0_STATS_EN
   logic [15:0] fire_cnt, store_cnt, drop_cnt;
`endif

   int n_chk = 0;
   int n_err = 0;

   logic [15:0] c_node;
   logic [11:0] c_gen;
   logic [31:0] c_oprl, c_oprr;
   logic        c_uni;
   logic [1:0]  c_wen;

   always #5 clk = ~clk;

   fc0_match_stage_if #(.NODE_W(DEF_NODE_W), .GEN_W(DEF_GEN_W), .OPR_W(DEF_OPR_W)) bus ();

   fc0_match_stage #(.DEPTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus),
      .occ_o (occ),
      .ovf_o (ovf),
      .dup_o (dup)
`ifdef FC0_STATS_EN
      ,
      .fire_cnt_o  (fire_cnt),
      .store_cnt_o (store_cnt),
      .drop_cnt_o  (drop_cnt)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic token_t mk(input logic lr, input logic [15:0] node, input logic [11:0] gen,
                                 input logic [31:0] opr, input logic uni, input logic [1:0] wen);
      token_t t;
      t.lr = lr; t.node = node; t.gen = gen; t.opr = opr; t.uni_opr = uni; t.mem_wen = wen;
      return t;
   endfunction

   task automatic send(input token_t t);
      bit ok;
      ok = 1'b0;
      @(negedge clk);
      bus.lr_i = t.lr; bus.node_i = t.node; bus.gen_i = t.gen; bus.opr_i = t.opr;
      bus.uni_opr_i = t.uni_opr; bus.mem_wen_i = t.mem_wen; bus.in_valid = 1'b1;
      for (int k = 0; k < 50; k++) begin
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) check("send_timeout", 0, 1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic settle();
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_out();
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("out_timeout", 0, 1);
   endtask

   task automatic get();
      wait_out();
      c_node = bus.node_o; c_gen = bus.gen_o; c_oprl = bus.oprl_o; c_oprr = bus.oprr_o;
      c_uni = bus.uni_o; c_wen = bus.mem_wen_o;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.lr_i = 1'b0; bus.node_i = '0; bus.gen_i = '0; bus.opr_i = '0;
      bus.uni_opr_i = 1'b0; bus.mem_wen_i = 2'b00; bus.out_ready = 1'b0;

      // Reset behaviour
      repeat (2) @(negedge clk);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_out_valid", bus.out_valid, 0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", bus.in_ready, 1);
      check("post_rst_occ", occ, 0);
      check("post_rst_ovf", ovf, 0);
      check("post_rst_dup", dup, 0);
      check("post_rst_oprl", bus.oprl_o, 0);

      // Basic fire, left first
      send(mk(1'b0, 16'h0012, 12'd3, 32'hA, 1'b0, 2'b00));
      settle();
      check("basic_occ1", occ, 1);
      send(mk(1'b1, 16'h0012, 12'd3, 32'hB, 1'b0, 2'b00));
      get();
      check("basic_oprl", c_oprl, 32'hA);
      check("basic_oprr", c_oprr, 32'hB);
      check("basic_uni", c_uni, 0);
      check("basic_node", c_node, 16'h0012);
      check("basic_gen", c_gen, 12'd3);
      check("basic_wen", c_wen, 2'b00);
      check("basic_occ0", occ, 0);

      // Reverse order
      send(mk(1'b1, 16'h0012, 12'd3, 32'hB, 1'b0, 2'b00));
      settle();
      check("rev_occ1", occ, 1);
      send(mk(1'b0, 16'h0012, 12'd3, 32'hA, 1'b0, 2'b00));
      get();
      check("rev_oprl", c_oprl, 32'hA);
      check("rev_oprr", c_oprr, 32'hB);
      check("rev_occ0", occ, 0);

      // Bypass: monadic and memory write
      send(mk(1'b0, 16'h0007, 12'd1, 32'h55, 1'b1, 2'b00));
      get();
      check("uni_oprl", c_oprl, 32'h55);
      check("uni_oprr", c_oprr, 0);
      check("uni_flag", c_uni, 1);
      check("uni_node", c_node, 16'h0007);
      check("uni_occ", occ, 0);
      send(mk(1'b1, 16'h0009, 12'd2, 32'h77, 1'b0, 2'b01));
      get();
      check("wen_fwd", c_wen, 2'b01);
      check("wen_uni", c_uni, 1);
      check("wen_oprl", c_oprl, 32'h77);

      // Differing generations must not pair
      send(mk(1'b0, 16'h0012, 12'd4, 32'h40, 1'b0, 2'b00));
      send(mk(1'b1, 16'h0012, 12'd5, 32'h51, 1'b0, 2'b00));
      settle();
      check("gen_occ2", occ, 2);
      check("gen_no_out", bus.out_valid, 0);

      // Backpressure on a fired packet
      send(mk(1'b0, 16'h0012, 12'd5, 32'h50, 1'b0, 2'b00));
      wait_out();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_valid", bus.out_valid, 1);
         check("bp_oprl", bus.oprl_o, 32'h50);
         check("bp_oprr", bus.oprr_o, 32'h51);
         check("bp_gen", bus.gen_o, 12'd5);
         check("bp_in_ready", bus.in_ready, 0);
      end
      get();
      check("bp_get_oprl", c_oprl, 32'h50);
      check("bp_occ1", occ, 1);
      send(mk(1'b1, 16'h0012, 12'd4, 32'h41, 1'b0, 2'b00));
      get();
      check("gen4_oprl", c_oprl, 32'h40);
      check("gen4_oprr", c_oprr, 32'h41);
      check("gen4_occ0", occ, 0);

      // Fill, overflow, duplicate
      for (int i = 0; i < 8; i++) begin
         send(mk(1'b0, 16'(i), 12'd0, 32'h100 + 32'(i), 1'b0, 2'b00));
      end
      settle();
      check("full_occ8", occ, 8);
      check("full_ovf0", ovf, 0);
      send(mk(1'b0, 16'd8, 12'd0, 32'h108, 1'b0, 2'b00));
      settle();
      check("ovf_set", ovf, 1);
      check("ovf_occ8", occ, 8);
      check("ovf_no_dup", dup, 0);
      send(mk(1'b0, 16'd0, 12'd0, 32'h1FF, 1'b0, 2'b00));
      settle();
      check("dup_set", dup, 1);
      check("dup_occ8", occ, 8);
      send(mk(1'b1, 16'd0, 12'd0, 32'h200, 1'b0, 2'b00));
      get();
      check("full_fire_oprl", c_oprl, 32'h100);
      check("full_fire_oprr", c_oprr, 32'h200);
      check("full_fire_occ7", occ, 7);
      check("ovf_sticky", ovf, 1);
      check("dup_sticky", dup, 1);
`ifdef FC0_STATS_EN
      check("stat_fire", fire_cnt, 16'd5);
      check("stat_store", store_cnt, 16'd12);
      check("stat_drop", drop_cnt, 16'd2);
`endif

      // Reset while a packet is held in EMIT
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         send(mk(1'b0, 16'h0020 + 16'(i), 12'd1, 32'(i), 1'b0, 2'b00));
      end
      send(mk(1'b0, 16'h0030, 12'd0, 32'h99, 1'b1, 2'b00));
      wait_out();
      check("mid_occ3", occ, 3);
      check("mid_valid", bus.out_valid, 1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_valid", bus.out_valid, 0);
      check("mid_rst_occ", occ, 0);
      check("mid_rst_in_ready", bus.in_ready, 0);
      check("mid_rst_ovf", ovf, 0);
      check("mid_rst_dup", dup, 0);
      check("mid_rst_oprl", bus.oprl_o, 0);
`ifdef FC0_STATS_EN
      check("mid_rst_fire", fire_cnt, 0);
      check("mid_rst_store", store_cnt, 0);
      check("mid_rst_drop", drop_cnt, 0);
`endif
      rst = 1'b0;
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
